conv_loop_controller: RTL and testbench

CONV_LOOP_CONTROLLER -- requirements
Module: conv_loop_controller

---
 rtl/conv_loop_controller.sv | 147 ++++++++++++++
 tb/tb_conv_loop_controller.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_loop_controller.sv
`default_nettype none
// ============================================================================
// Module      : conv_loop_controller
// Description : Loop sequencer for a convolution MAC datapath (kernel, channel
//               and output-coordinate loops with a one-cycle writeback).
// Revision    : 1.0
// ============================================================================
module conv_loop_controller #(
   parameter int FEATURE_MAP_WIDTH  = 64,
   parameter int FEATURE_MAP_HEIGHT = 64,
   parameter int INPUT_NB_CHANNELS  = 4,
   parameter int OUTPUT_NB_CHANNELS = 32,
   parameter int KERNEL_SIZE        = 3,
   localparam int XW  = $clog2((FEATURE_MAP_WIDTH  > 2) ? FEATURE_MAP_WIDTH  : 2),
   localparam int YW  = $clog2((FEATURE_MAP_HEIGHT > 2) ? FEATURE_MAP_HEIGHT : 2),
   localparam int CIW = $clog2((INPUT_NB_CHANNELS  > 2) ? INPUT_NB_CHANNELS  : 2),
   localparam int COW = $clog2((OUTPUT_NB_CHANNELS > 2) ? OUTPUT_NB_CHANNELS : 2),
   localparam int KW  = $clog2((KERNEL_SIZE        > 2) ? KERNEL_SIZE        : 2)
) (
   input  logic           clk,
   input  logic           arst_n_in,
   input  logic           start,
   output logic           running,
   input  logic           a_valid,
   input  logic           b_valid,
   output logic           a_ready,
   output logic           b_ready,
   output logic           mac_valid,
   output logic           acc_clear,
   output logic [KW-1:0]  k_x,
   output logic [KW-1:0]  k_y,
   output logic [CIW-1:0] in_ch,
   output logic [XW-1:0]  output_x,
   output logic [YW-1:0]  output_y,
   output logic [COW-1:0] output_ch,
   output logic           output_valid
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_WB   = 2'd2
   } state_t;

   localparam logic [KW-1:0]  c_k_last  = KW'(KERNEL_SIZE - 1);
   localparam logic [CIW-1:0] c_ci_last = CIW'(INPUT_NB_CHANNELS - 1);
   localparam logic [XW-1:0]  c_x_last  = XW'(FEATURE_MAP_WIDTH - 1);
   localparam logic [YW-1:0]  c_y_last  = YW'(FEATURE_MAP_HEIGHT - 1);
   localparam logic [COW-1:0] c_co_last = COW'(OUTPUT_NB_CHANNELS - 1);

   state_t           r_state;
   logic [KW-1:0]    r_k_x;
   logic [KW-1:0]    r_k_y;
   logic [CIW-1:0]   r_in_ch;
   logic [XW-1:0]    r_out_x;
   logic [YW-1:0]    r_out_y;
   logic [COW-1:0]   r_out_ch;

   logic w_run;
   logic w_fire;

   // Each ready depends on the other operand so a pair is always consumed together.
   assign w_run   = (r_state == ST_RUN);
   assign w_fire  = w_run && a_valid && b_valid;

   assign running      = (r_state != ST_IDLE);
   assign output_valid = (r_state == ST_WB);
   assign a_ready      = w_run && b_valid;
   assign b_ready      = w_run && a_valid;
   assign mac_valid    = w_fire;
   assign acc_clear    = w_fire && (r_k_x == '0) && (r_k_y == '0) && (r_in_ch == '0);
   assign k_x          = r_k_x;
   assign k_y          = r_k_y;
   assign in_ch        = r_in_ch;
   assign output_x     = r_out_x;
   assign output_y     = r_out_y;
   assign output_ch    = r_out_ch;

   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         r_state  <= ST_IDLE;
         r_k_x    <= '0;
         r_k_y    <= '0;
         r_in_ch  <= '0;
         r_out_x  <= '0;
         r_out_y  <= '0;
         r_out_ch <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_state  <= ST_RUN;
                  r_k_x    <= '0;
                  r_k_y    <= '0;
                  r_in_ch  <= '0;
                  r_out_x  <= '0;
                  r_out_y  <= '0;
                  r_out_ch <= '0;
               end
            end
            ST_RUN: begin
               if (w_fire) begin
                  if (r_k_x == c_k_last) begin
                     r_k_x <= '0;
                     if (r_k_y == c_k_last) begin
                        r_k_y <= '0;
                        if (r_in_ch == c_ci_last) begin
                           r_in_ch <= '0;
                           r_state <= ST_WB;
                        end else begin
                           r_in_ch <= r_in_ch + CIW'(1);
                        end
                     end else begin
                        r_k_y <= r_k_y + KW'(1);
                     end
                  end else begin
                     r_k_x <= r_k_x + KW'(1);
                  end
               end
            end
            ST_WB: begin
               // Outer coordinates stay put during WB so they name the finished output.
               r_state <= ST_RUN;
               if (r_out_ch == c_co_last) begin
                  r_out_ch <= '0;
                  if (r_out_x == c_x_last) begin
                     r_out_x <= '0;
                     if (r_out_y == c_y_last) begin
                        r_out_y <= '0;
                        r_state <= ST_IDLE;
                     end else begin
                        r_out_y <= r_out_y + YW'(1);
                     end
                  end else begin
                     r_out_x <= r_out_x + XW'(1);
                  end
               end else begin
                  r_out_ch <= r_out_ch + COW'(1);
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_conv_loop_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_loop_controller
// Description : Self-checking bench: table vectors, reference loop model and
//               output-coordinate scoreboard for conv_loop_controller.
// Revision    : 1.0
// ============================================================================
module tb_conv_loop_controller;

   localparam int W    = 2;
   localparam int H    = 2;
   localparam int CI   = 2;
   localparam int CO   = 2;
   localparam int K    = 2;
   localparam int NOUT = W * H * CO;
   localparam int NF   = K * K * CI;

   logic clk = 1'b0;
   logic arst_n, start, a_valid, b_valid;
   logic running, a_ready, b_ready, mac_valid, acc_clear, output_valid;
   logic k_x, k_y, in_ch, output_x, output_y, output_ch;

   logic d_start, d_a, d_b;
   logic d_running, d_a_ready, d_b_ready, d_mac, d_clr, d_ov;
   logic d_kx, d_ky, d_inch, d_ox, d_oy, d_och;

   always #5 clk = ~clk;

   conv_loop_controller #(
      .FEATURE_MAP_WIDTH(W), .FEATURE_MAP_HEIGHT(H), .INPUT_NB_CHANNELS(CI),
      .OUTPUT_NB_CHANNELS(CO), .KERNEL_SIZE(K)
   ) dut (
      .clk(clk), .arst_n_in(arst_n), .start(start), .running(running),
      .a_valid(a_valid), .b_valid(b_valid), .a_ready(a_ready), .b_ready(b_ready),
      .mac_valid(mac_valid), .acc_clear(acc_clear), .k_x(k_x), .k_y(k_y),
      .in_ch(in_ch), .output_x(output_x), .output_y(output_y),
      .output_ch(output_ch), .output_valid(output_valid)
   );

   conv_loop_controller #(
      .FEATURE_MAP_WIDTH(2), .FEATURE_MAP_HEIGHT(2), .INPUT_NB_CHANNELS(1),
      .OUTPUT_NB_CHANNELS(1), .KERNEL_SIZE(1)
   ) dut_deg (
      .clk(clk), .arst_n_in(arst_n), .start(d_start), .running(d_running),
      .a_valid(d_a), .b_valid(d_b), .a_ready(d_a_ready), .b_ready(d_b_ready),
      .mac_valid(d_mac), .acc_clear(d_clr), .k_x(d_kx), .k_y(d_ky),
      .in_ch(d_inch), .output_x(d_ox), .output_y(d_oy),
      .output_ch(d_och), .output_valid(d_ov)
   );

   typedef struct {
      int x;
      int y;
      int ch;
   } coord_t;

   typedef struct {
      logic       a;
      logic       b;
      logic       st;
      logic [4:0] e_ctl;   // {running, a_ready, b_ready, mac_valid, acc_clear}
      logic [2:0] e_k;     // {k_x, k_y, in_ch}
   } row_t;

   coord_t sb[$];
   row_t   rows[9];

   int n_checks = 0;
   int n_fail   = 0;
   int n_fire, n_out, n_clear, n_run;
   int m_state, m_fires, m_out;   // model state: 0 idle, 1 run, 2 writeback

   task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   function automatic coord_t coord_of(input int idx);
      coord_t c;
      c.ch = idx % CO;
      c.x  = (idx / CO) % W;
      c.y  = idx / (CO * W);
      return c;
   endfunction

   task automatic reset_counters();
      n_fire = 0; n_out = 0; n_clear = 0; n_run = 0;
   endtask

   task automatic check_cycle(input logic a, input logic b);
      logic       e_fire;
      logic [11:0] e, g;
      coord_t     c, p;
      c      = coord_of(m_out);
      e_fire = (m_state == 1) && a && b;
      e = {m_state != 0, (m_state == 1) && b, (m_state == 1) && a, e_fire,
           e_fire && (m_fires == 0), m_state == 2,
           1'(m_fires % K), 1'((m_fires / K) % K), 1'(m_fires / (K * K)),
           1'(c.x), 1'(c.y), 1'(c.ch)};
      g = {running, a_ready, b_ready, mac_valid, acc_clear, output_valid,
           k_x, k_y, in_ch, output_x, output_y, output_ch};
      cmp("cycle_outputs", 64'(g), 64'(e));
      if (mac_valid) n_fire++;
      if (acc_clear) n_clear++;
      if (running)   n_run++;
      if (output_valid) begin
         n_out++;
         cmp("sb_has_entry", 64'(sb.size() != 0), 64'd1);
         if (sb.size() != 0) begin
            p = sb.pop_front();
            cmp("out_coord", 64'({output_x, output_y, output_ch}),
                64'({1'(p.x), 1'(p.y), 1'(p.ch)}));
         end
      end
   endtask

   task automatic model_edge(input logic a, input logic b, input logic st);
      case (m_state)
         0: if (st) begin m_state = 1; m_fires = 0; m_out = 0; end
         1: if (a && b) begin
               m_fires++;
               if (m_fires == NF) begin
                  sb.push_back(coord_of(m_out));
                  m_fires = 0;
                  m_state = 2;
               end
            end
         default: begin
               m_out++;
               if (m_out == NOUT) begin m_out = 0; m_state = 0; end
               else m_state = 1;
            end
      endcase
   endtask

   task automatic apply(input logic a, input logic b, input logic st);
      a_valid = a; b_valid = b; start = st;
      #1;
      check_cycle(a, b);
      model_edge(a, b, st);
      @(negedge clk);
   endtask

   task automatic run_to_idle(input string name, input bit rnd);
      logic a, b, st;
      for (int c = 0; c < 3000 && m_state != 0; c++) begin
         a  = rnd ? ($urandom_range(3) != 0) : 1'b1;
         b  = rnd ? ($urandom_range(3) != 0) : 1'b1;
         st = rnd ? ($urandom_range(5) == 0) : 1'b0;
         apply(a, b, st);
      end
      #1;
      cmp({name, "_idle"}, 64'(running), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rows[0] = '{1'b0, 1'b0, 1'b0, 5'b00000, 3'b000};
      rows[1] = '{1'b1, 1'b0, 1'b1, 5'b00000, 3'b000};
      rows[2] = '{1'b1, 1'b0, 1'b0, 5'b10100, 3'b000};
      rows[3] = '{1'b1, 1'b1, 1'b0, 5'b11111, 3'b000};
      rows[4] = '{1'b1, 1'b0, 1'b0, 5'b10100, 3'b100};
      rows[5] = '{1'b0, 1'b1, 1'b0, 5'b11000, 3'b100};
      rows[6] = '{1'b1, 1'b1, 1'b1, 5'b11110, 3'b100};
      rows[7] = '{1'b0, 1'b0, 1'b0, 5'b10000, 3'b010};
      rows[8] = '{1'b1, 1'b1, 1'b0, 5'b11110, 3'b010};

      m_state = 0; m_fires = 0; m_out = 0;
      reset_counters();
      arst_n = 1'b0; start = 1'b0; a_valid = 1'b1; b_valid = 1'b1;
      d_start = 1'b0; d_a = 1'b1; d_b = 1'b1;
      #2;
      cmp("reset_main", 64'({running, a_ready, b_ready, mac_valid, acc_clear, output_valid,
                             k_x, k_y, in_ch, output_x, output_y, output_ch}), 64'd0);
      cmp("reset_deg", 64'({d_running, d_a_ready, d_b_ready, d_mac, d_clr, d_ov,
                            d_kx, d_ky, d_inch, d_ox, d_oy, d_och}), 64'd0);
      #6 arst_n = 1'b1;
      d_a = 1'b0; d_b = 1'b0;
      @(negedge clk);

      // Table vectors: start, half handshakes and a start pulse while running.
      for (int i = 0; i < 9; i++) begin
         a_valid = rows[i].a; b_valid = rows[i].b; start = rows[i].st;
         #1;
         cmp($sformatf("row%0d", i),
             64'({running, a_ready, b_ready, mac_valid, acc_clear, k_x, k_y, in_ch}),
             64'({rows[i].e_ctl, rows[i].e_k}));
         check_cycle(rows[i].a, rows[i].b);
         model_edge(rows[i].a, rows[i].b, rows[i].st);
         @(negedge clk);
      end
      run_to_idle("random_run", 1'b1);
      cmp("random_fires", 64'(n_fire), 64'd64);
      cmp("random_outputs", 64'(n_out), 64'd8);

      // Continuous operands: 8 x (8 fires + 1 writeback) busy cycles.
      reset_counters();
      apply(1'b1, 1'b1, 1'b1);
      run_to_idle("basic_run", 1'b0);
      cmp("basic_busy_cycles", 64'(n_run), 64'd72);
      cmp("basic_fires", 64'(n_fire), 64'd64);
      cmp("basic_clears", 64'(n_clear), 64'd8);
      cmp("basic_outputs", 64'(n_out), 64'd8);

      // Reset after 20 fires, then a complete fresh run.
      reset_counters();
      apply(1'b1, 1'b1, 1'b1);
      for (int c = 0; c < 100 && n_fire < 20; c++) apply(1'b1, 1'b1, 1'b0);
      cmp("midrun_fires", 64'(n_fire), 64'd20);
      a_valid = 1'b1; b_valid = 1'b1; start = 1'b0;
      #2 arst_n = 1'b0;
      #1;
      cmp("midrun_reset_outputs",
          64'({running, a_ready, b_ready, mac_valid, acc_clear, output_valid,
               k_x, k_y, in_ch, output_x, output_y, output_ch}), 64'd0);
      m_state = 0; m_fires = 0; m_out = 0;
      sb.delete();
      #5 arst_n = 1'b1;
      @(negedge clk);
      apply(1'b1, 1'b1, 1'b0);
      reset_counters();
      apply(1'b1, 1'b1, 1'b1);
      run_to_idle("after_reset_run", 1'b0);
      cmp("after_reset_outputs", 64'(n_out), 64'd8);
      cmp("after_reset_fires", 64'(n_fire), 64'd64);

      // Degenerate K=1, Cin=1, Cout=1: fire and writeback alternate.
      a_valid = 1'b0; b_valid = 1'b0;
      d_a = 1'b1; d_b = 1'b1; d_start = 1'b1;
      #1;
      cmp("deg_idle_on_start", 64'(d_running), 64'd0);
      @(negedge clk);
      d_start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         coord_t p;
         #1;
         if (i % 2 == 0) begin
            cmp($sformatf("deg_fire%0d", i / 2),
                64'({d_running, d_a_ready, d_b_ready, d_mac, d_clr, d_ov, d_kx, d_ky, d_inch}),
                64'(9'b111110000));
            p.x = (i / 2) % 2; p.y = (i / 2) / 2; p.ch = 0;
            sb.push_back(p);
         end else begin
            cmp($sformatf("deg_wb%0d", i / 2),
                64'({d_running, d_a_ready, d_b_ready, d_mac, d_clr, d_ov, d_kx, d_ky, d_inch}),
                64'(9'b100001000));
            cmp("deg_sb_has_entry", 64'(sb.size() != 0), 64'd1);
            if (d_ov && sb.size() != 0) begin
               p = sb.pop_front();
               cmp($sformatf("deg_coord%0d", i / 2), 64'({d_ox, d_oy, d_och}),
                   64'({1'(p.x), 1'(p.y), 1'(p.ch)}));
            end
         end
         @(negedge clk);
      end
      #1;
      cmp("deg_done", 64'(d_running), 64'd0);
      cmp("sb_drained", 64'(sb.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
